// File: rtl/exp_series_datapath.sv
// Exponential-series datapath: accumulates sum of x^k/k! for k = 0..N_TERMS-1, one term per ldTmp pulse.
// Optional saturation of the running sum on overflow is enabled by defining EXP_DP_SAT_EN (default build wraps).
module exp_series_datapath #(
  parameter int FRAC    = 16,
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FRAC:0]   x_in,
  input  logic            ldX,
  input  logic            selTmp,
  input  logic            ldTmp,
  output logic            done,
  output logic [FRAC+1:0] result,
  output logic            result_valid,
  output logic            overflow
);

  localparam int SW = FRAC + 2;
  localparam logic [SW-1:0]    ONE     = {2'b01, {FRAC{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TERMS   = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_TERMS - 1);

  typedef logic [FRAC:0] coef_t;

  // Rounded reciprocal 1/k in Q1.FRAC; evaluated at elaboration only.
  function automatic coef_t coef_of(input int k);
    logic [63:0] num;
    num = (64'd1 << FRAC) + 64'(k / 2);
    return coef_t'(num / 64'(k));
  endfunction

  coef_t coef_rom [1:15];
  for (genvar k = 1; k <= 15; k++) begin : g_rom
    assign coef_rom[k] = coef_of(k);
  end

  logic [FRAC:0]    x_q, x_d;
  logic [SW-1:0]    tmp_q, tmp_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W:0]    idx;
  coef_t             coef_sel;
  logic [2*FRAC+2:0] prod_tx;
  logic [FRAC+2:0]   tx_scaled;
  logic [2*FRAC+3:0] prod_coef;
  logic [SW-1:0]     nt;
  logic [SW:0]       add_full;

  assign idx = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Indices beyond the ROM only occur once the series is finished, when nt is unused.
  always_comb begin
    coef_sel = '0;
    for (int k = 1; k <= 15; k++) begin
      if (int'(idx) == k) coef_sel = coef_rom[k];
    end
  end

  assign prod_tx   = {{(FRAC+1){1'b0}}, tmp_q} * {{(FRAC+2){1'b0}}, x_q};
  assign tx_scaled = (FRAC+3)'(prod_tx >> FRAC);
  assign prod_coef = {{(FRAC+1){1'b0}}, tx_scaled} * {{(FRAC+3){1'b0}}, coef_sel};
  assign nt        = SW'(prod_coef >> FRAC);

  assign add_full = {1'b0, sum_q} + {1'b0, tmp_q};

  // Strobe decode: init takes priority over accumulate; X loads independently.
  always_comb begin
    x_d     = x_q;
    tmp_d   = tmp_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (ldX) x_d = x_in;
    if (ldTmp && selTmp) begin
      tmp_d   = ONE;
      sum_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (ldTmp && (cnt_q < TERMS)) begin
`ifdef EXP_DP_SAT_EN
      sum_d = add_full[SW] ? {SW{1'b1}} : add_full[SW-1:0];
`else
      sum_d = add_full[SW-1:0];
`endif
      tmp_d = nt;
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == LAST) valid_d = 1'b1;
      if (add_full[SW]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      tmp_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      tmp_q   <= tmp_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign done         = (cnt_q == LAST);
  assign result       = sum_q;
  assign result_valid = valid_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_exp_series_datapath.sv
// Self-checking bench for exp_series_datapath: scoreboard of expected sums from a spec-level arithmetic model.
// Two instances: N_TERMS=4 for the main series checks, N_TERMS=8 for overflow behaviour.
module tb_exp_series_datapath;

  localparam int N4 = 4;
  localparam int N8 = 8;
  localparam longint unsigned MASK = (64'd1 << 18) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [16:0] x_in;
  logic        ldX, selTmp, ldTmp, done;
  logic [17:0] result;
  logic        result_valid, overflow;

  logic [16:0] x8;
  logic        ldX8, sel8, ldTmp8, done8;
  logic [17:0] result8;
  logic        rv8, ovf8;

  exp_series_datapath #(.FRAC(16), .N_TERMS(N4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .ldX(ldX), .selTmp(selTmp), .ldTmp(ldTmp),
    .done(done), .result(result), .result_valid(result_valid), .overflow(overflow));

  exp_series_datapath #(.FRAC(16), .N_TERMS(N8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .x_in(x8), .ldX(ldX8), .selTmp(sel8), .ldTmp(ldTmp8),
    .done(done8), .result(result8), .result_valid(rv8), .overflow(ovf8));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [17:0] sum;
    logic        valid;
    logic        ovf;
    logic        done;
  } exp_t;
  exp_t sb[$];

  longint unsigned m_x, m_tmp, m_sum;
  int m_cnt;
  bit m_valid, m_ovf;

  function automatic longint unsigned coef_m(input int k);
    if (k < 1 || k > 15) return 0;
    return (64'd65536 + longint'(k / 2)) / longint'(k);
  endfunction

  function automatic longint unsigned next_term(input longint unsigned tmp, input longint unsigned x, input int k);
    return ((((tmp * x) >> 16) * coef_m(k)) >> 16) & MASK;
  endfunction

  task automatic model_reset();
    m_x = 0; m_tmp = 0; m_sum = 0; m_cnt = 0; m_valid = 0; m_ovf = 0;
  endtask

  // Drive one cycle of strobes on the N=4 instance, advance the model and push the expectation.
  task automatic drive_pulse(input logic lx, input logic [16:0] xv, input logic sel,
                             input logic lt, output logic obs_done);
    exp_t e;
    longint unsigned s;
    @(negedge clk);
    ldX = lx; x_in = xv; selTmp = sel; ldTmp = lt;
    #1 obs_done = done;
    e.done = (m_cnt == N4 - 1);
    if (lt && sel) begin
      m_tmp = 64'd65536; m_sum = 0; m_cnt = 0; m_valid = 0; m_ovf = 0;
    end else if (lt && m_cnt < N4) begin
      s = m_sum + m_tmp;
      if (s > MASK) begin
        m_ovf = 1;
`ifdef EXP_DP_SAT_EN
        s = MASK;
`endif
      end
      m_sum = s & MASK;
      m_tmp = next_term(m_tmp, m_x, m_cnt + 1);
      if (m_cnt == N4 - 1) m_valid = 1;
      m_cnt++;
    end
    if (lx) m_x = longint'(xv);
    e.sum = 18'(m_sum); e.valid = m_valid; e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ldX = 0; selTmp = 0; ldTmp = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (result !== 18'h0)     begin errors++; $display("[TB] FAIL reset_result: got %h want %h", result, 18'h0); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", result_valid); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (done !== 1'b0)         begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic d;
    drive_pulse(1, 17'h10000, 1, 1, d); e = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
      checks++; if (result !== e.sum) begin errors++; $display("[TB] FAIL midrst_pre_sum%0d: got %h want %h", i, result, e.sum); end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (result !== 18'h0)      begin errors++; $display("[TB] FAIL midrst_result: got %h want 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", result_valid); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_overflow: got %b want 0", overflow); end
    checks++; if (done !== 1'b0)         begin errors++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // Accumulating without an init runs from Tmp=0: sum stays 0 while the counter advances.
    for (int i = 0; i < N4; i++) begin
      drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
      checks++; if (d !== e.done)     begin errors++; $display("[TB] FAIL noinit_done%0d: got %b want %b", i, d, e.done); end
      checks++; if (result !== e.sum) begin errors++; $display("[TB] FAIL noinit_sum%0d: got %h want %h", i, result, e.sum); end
    end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL noinit_valid: got %b want 1", result_valid); end
  endtask

  task automatic test_series(input string name, input logic [16:0] xv, input logic [17:0] final_sum);
    exp_t e;
    logic d;
    drive_pulse(1, xv, 1, 1, d); e = sb.pop_front();
    checks++; if (result !== 18'h0) begin errors++; $display("[TB] FAIL %s_init_sum: got %h want 0", name, result); end
    for (int i = 0; i < N4; i++) begin
      drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
      checks++; if (d !== e.done)               begin errors++; $display("[TB] FAIL %s_done%0d: got %b want %b", name, i, d, e.done); end
      checks++; if (result !== e.sum)           begin errors++; $display("[TB] FAIL %s_sum%0d: got %h want %h", name, i, result, e.sum); end
      checks++; if (result_valid !== e.valid)   begin errors++; $display("[TB] FAIL %s_valid%0d: got %b want %b", name, i, result_valid, e.valid); end
      checks++; if (overflow !== e.ovf)         begin errors++; $display("[TB] FAIL %s_ovf%0d: got %b want %b", name, i, overflow, e.ovf); end
    end
    checks++; if (result !== final_sum) begin errors++; $display("[TB] FAIL %s_final: got %h want %h", name, result, final_sum); end
  endtask

  task automatic test_extra_pulse();
    exp_t e;
    logic d;
    drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
    checks++; if (d !== 1'b0)            begin errors++; $display("[TB] FAIL extra_done: got %b want 0", d); end
    checks++; if (result !== 18'h10000)  begin errors++; $display("[TB] FAIL extra_sum: got %h want %h", result, 18'h10000); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL extra_valid: got %b want 1", result_valid); end
  endtask

  task automatic test_reinit();
    exp_t e;
    logic d;
    drive_pulse(1, 17'h10000, 1, 1, d); e = sb.pop_front();
    drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
    drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
    checks++; if (result !== e.sum) begin errors++; $display("[TB] FAIL reinit_pre_sum: got %h want %h", result, e.sum); end
    drive_pulse(1, 17'h08000, 1, 1, d); e = sb.pop_front();
    checks++; if (result !== 18'h0)      begin errors++; $display("[TB] FAIL reinit_sum: got %h want 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reinit_valid: got %b want 0", result_valid); end
    checks++; if (done !== 1'b0)         begin errors++; $display("[TB] FAIL reinit_done: got %b want 0", done); end
    for (int i = 0; i < N4; i++) begin
      drive_pulse(0, 17'h0, 0, 1, d); e = sb.pop_front();
      checks++; if (result !== e.sum) begin errors++; $display("[TB] FAIL reinit_sum%0d: got %h want %h", i, result, e.sum); end
    end
    checks++; if (result !== 18'h1A555)  begin errors++; $display("[TB] FAIL reinit_final: got %h want %h", result, 18'h1A555); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL reinit_final_valid: got %b want 1", result_valid); end
  endtask

  // N=8 instance: x just below 2.0 drives the sum past 4.0; then re-init must clear the flag.
  task automatic test_overflow();
    exp_t q8[$];
    exp_t e;
    longint unsigned t, s, xv;
    bit ovf;
    xv = 64'h1FFFF; t = 64'd65536; s = 0; ovf = 0;
    @(negedge clk); ldX8 = 1; x8 = 17'h1FFFF; sel8 = 1; ldTmp8 = 1;
    @(posedge clk); #1; ldX8 = 0; sel8 = 0; ldTmp8 = 0;
    for (int k = 0; k < N8; k++) begin
      @(negedge clk); ldTmp8 = 1;
      #1;
      checks++; if (done8 !== (k == N8 - 1)) begin errors++; $display("[TB] FAIL ovf_done%0d: got %b want %b", k, done8, (k == N8 - 1)); end
      s = s + t;
      if (s > MASK) begin
        ovf = 1;
`ifdef EXP_DP_SAT_EN
        s = MASK;
`endif
      end
      s = s & MASK;
      t = next_term(t, xv, k + 1);
      e.sum = 18'(s); e.ovf = ovf; e.valid = (k == N8 - 1); e.done = 1'b0;
      q8.push_back(e);
      @(posedge clk); #1; ldTmp8 = 0;
      e = q8.pop_front();
      checks++; if (result8 !== e.sum) begin errors++; $display("[TB] FAIL ovf_sum%0d: got %h want %h", k, result8, e.sum); end
      checks++; if (ovf8 !== e.ovf)    begin errors++; $display("[TB] FAIL ovf_flag%0d: got %b want %b", k, ovf8, e.ovf); end
      checks++; if (rv8 !== e.valid)   begin errors++; $display("[TB] FAIL ovf_valid%0d: got %b want %b", k, rv8, e.valid); end
    end
`ifdef EXP_DP_SAT_EN
    checks++; if (result8 !== 18'h3FFFF) begin errors++; $display("[TB] FAIL ovf_saturated: got %h want %h", result8, 18'h3FFFF); end
`endif
    checks++; if (ovf8 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf8); end
    @(negedge clk); ldX8 = 1; x8 = 17'h0; sel8 = 1; ldTmp8 = 1;
    @(posedge clk); #1; ldX8 = 0; sel8 = 0; ldTmp8 = 0;
    checks++; if (ovf8 !== 1'b0)    begin errors++; $display("[TB] FAIL ovf_cleared: got %b want 0", ovf8); end
    checks++; if (result8 !== 18'h0) begin errors++; $display("[TB] FAIL ovf_reinit_sum: got %h want 0", result8); end
    for (int k = 0; k < N8; k++) begin
      @(negedge clk); ldTmp8 = 1;
      @(posedge clk); #1; ldTmp8 = 0;
    end
    checks++; if (result8 !== 18'h10000) begin errors++; $display("[TB] FAIL ovf_after_sum: got %h want %h", result8, 18'h10000); end
    checks++; if (rv8 !== 1'b1)          begin errors++; $display("[TB] FAIL ovf_after_valid: got %b want 1", rv8); end
    checks++; if (ovf8 !== 1'b0)         begin errors++; $display("[TB] FAIL ovf_after_flag: got %b want 0", ovf8); end
  endtask

  initial begin
    x_in = '0; ldX = 0; selTmp = 0; ldTmp = 0;
    x8 = '0; ldX8 = 0; sel8 = 0; ldTmp8 = 0;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_mid_reset();
    test_series("x_one", 17'h10000, 18'h2AAAA);
    test_series("x_half", 17'h08000, 18'h1A555);
    test_series("x_zero", 17'h00000, 18'h10000);
    test_extra_pulse();
    test_reinit();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
